// File: rtl/crc_compute_pkg.sv
// Shared types and constants for the free-running word CRC engine.
// Holds the FSM state encoding, default widths and the beat count.
package crc_compute_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CRC_W_DEF  = 6;
    localparam int BPC_DEF    = 4;
    localparam int NUM_BEATS  = DATA_W_DEF / BPC_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int beats(input int dw, input int bpc);
        return dw / bpc;
    endfunction

endpackage

// File: rtl/crc_nibble_step.sv
// Combinational CRC update over a small group of message bits.
// Bits are applied MSB-first; the x^CRC_W term of the generator is implicit.
module crc_nibble_step
    import crc_compute_pkg::*;
#(
    parameter int CRC_W = CRC_W_DEF,
    parameter int BITS  = BPC_DEF
) (
    input  logic [CRC_W-1:0] i_crc_in,
    input  logic [CRC_W-1:0] i_poly,
    input  logic [BITS-1:0]  i_bits,
    output logic [CRC_W-1:0] o_crc_out
);

    logic [CRC_W-1:0] w_crc;
    logic             w_fb;

    always_comb begin
        w_crc = i_crc_in;
        w_fb  = 1'b0;
        for (int i = BITS - 1; i >= 0; i--) begin
            w_fb  = w_crc[CRC_W-1] ^ i_bits[i];
            w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? i_poly : '0);
        end
        o_crc_out = w_crc;
    end

endmodule

// File: rtl/crc_compute.sv
// Free-running CRC engine: capture a word, fold it in BITS_PER_CYCLE bits per
// cycle, publish the remainder, and repeat with a fixed period of BEATS+2.
module crc_compute
    import crc_compute_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CRC_W          = CRC_W_DEF,
    parameter int BITS_PER_CYCLE = BPC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CRC_W-1:0]  CRC_polynomial,
    output logic [CRC_W-1:0]  CRC_out
);

    localparam int BEATS = beats(DATA_W, BITS_PER_CYCLE);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_beat;
    logic [DATA_W-1:0]   r_shift;
    logic [CRC_W-1:0]    r_poly;
    logic [CRC_W-1:0]    r_crc;
    logic [CRC_W-1:0]    w_crc_step;
    logic                w_last;
    logic                w_capture;
    logic                w_step;
    logic                w_load;

    assign w_last = (r_beat == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = CALC;
            CALC:    w_next = w_last ? DONE : CALC;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_load    = 1'b0;
        unique case (r_state)
            IDLE:    w_capture = 1'b1;
            CALC:    w_step    = 1'b1;
            DONE:    w_load    = 1'b1;
            default: w_capture = 1'b0;
        endcase
    end

    crc_nibble_step #(
        .CRC_W (CRC_W),
        .BITS  (BITS_PER_CYCLE)
    ) u_step (
        .i_crc_in  (r_crc),
        .i_poly    (r_poly),
        .i_bits    (r_shift[DATA_W-1 -: BITS_PER_CYCLE]),
        .o_crc_out (w_crc_step)
    );

    // Inputs are only looked at in IDLE, so the word in flight is immune to
    // changes on data_in / CRC_polynomial during CALC and DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat  <= '0;
            r_shift <= '0;
            r_poly  <= '0;
            r_crc   <= '0;
            CRC_out <= '0;
        end else begin
            if (w_capture) begin
                r_shift <= data_in;
                r_poly  <= CRC_polynomial;
                r_crc   <= '0;
                r_beat  <= '0;
            end
            if (w_step) begin
                r_crc   <= w_crc_step;
                r_shift <= r_shift << BITS_PER_CYCLE;
                r_beat  <= r_beat + CNT_W'(1);
            end
            if (w_load) CRC_out <= r_crc;
        end
    end

endmodule

// File: tb/tb_crc_compute.sv
// Self-checking bench: polynomial long-division model plus a 10-cycle
// schedule tracker, checked every cycle, with hand-computed directed vectors.
module tb_crc_compute;
    import crc_compute_pkg::*;

    localparam int DW = 32;
    localparam int CW = 6;
    localparam int PERIOD = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = 32'hDEADBEEF;
    logic [CW-1:0] poly = 6'h21;
    logic [CW-1:0] crc_out;

    int checks = 0;
    int failures = 0;

    crc_compute #(.DATA_W(DW), .CRC_W(CW), .BITS_PER_CYCLE(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .CRC_polynomial (poly),
        .CRC_out        (crc_out)
    );

    always #5 clk = ~clk;

    // (M(x) * x^CW) mod (x^CW + poly) by long division over GF(2).
    function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] d, input logic [CW-1:0] p);
        logic [DW+CW-1:0] v;
        logic [DW+CW-1:0] g;
        v = {d, {CW{1'b0}}};
        g = {{(DW-1){1'b0}}, 1'b1, p};
        for (int i = DW + CW - 1; i >= CW; i--)
            if (v[i]) v = v ^ (g << (i - CW));
        return v[CW-1:0];
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Schedule model: after release, edge 0 of each period captures, edge 9 publishes.
    int            phase = 0;
    int            done_cnt = 0;
    logic [DW-1:0] cap_d = '0;
    logic [CW-1:0] cap_p = '0;
    logic [CW-1:0] exp_crc = '0;

    always @(negedge reset) begin
        phase   = 0;
        exp_crc = '0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            phase   = 0;
            exp_crc = '0;
        end else begin
            if (phase == 0) begin
                cap_d = data_in;
                cap_p = poly;
            end
            if (phase == PERIOD - 1) begin
                exp_crc = crc_ref(cap_d, cap_p);
                done_cnt++;
            end
            phase = (phase + 1) % PERIOD;
        end
    end

    always @(negedge clk) check("cycle_crc_out", crc_out, exp_crc);

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the next publishing edge; reports edges waited.
    task automatic wait_done(output int edges);
        int n0;
        n0 = done_cnt;
        edges = 0;
        while (done_cnt == n0 && edges < 3 * PERIOD) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (done_cnt == n0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: timeout after %0d edges, expected a DONE", edges);
        end
    endtask

    initial begin
        int e;
        logic [DW-1:0] rd;
        logic [CW-1:0] rp;

        // Model pinned to hand-derived remainders.
        check("model_1",    crc_ref(32'h00000001, 6'h21), 6'h21);
        check("model_2",    crc_ref(32'h00000002, 6'h21), 6'h23);
        check("model_bbdd", crc_ref(32'hBBBBDDDD, 6'h21), 6'h1F);

        // Held in reset with live data.
        step(4);
        check("reset_out", crc_out, 6'h00);
        checks++;
        if (dut.r_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
        end

        data_in = 32'h00000001;
        poly    = 6'h21;
        @(posedge clk); #1;
        reset = 1'b1;
        wait_done(e);
        check("latency_first", 6'(e), 6'(PERIOD));
        check("vec_1", crc_out, 6'h21);

        data_in = 32'h00000002;
        wait_done(e);
        check("vec_2", crc_out, 6'h23);
        check("period", 6'(e), 6'(PERIOD));

        data_in = 32'hBBBBDDDD;
        wait_done(e);
        check("vec_bbdd", crc_out, 6'h1F);
        wait_done(e);
        check("vec_bbdd_again", crc_out, 6'h1F);

        // Mid-CALC change of data_in must not disturb the word in flight.
        step(5);
        data_in = 32'h00000000;
        wait_done(e);
        check("midcalc_old_word", crc_out, 6'h1F);
        wait_done(e);
        check("midcalc_new_word", crc_out, 6'h00);

        data_in = 32'hA5C3F00F;
        poly    = 6'h00;
        wait_done(e);
        check("poly_zero", crc_out, 6'h00);

        data_in = 32'h00000001;
        poly    = 6'h21;
        wait_done(e);
        check("pre_abort", crc_out, 6'h21);

        // Asynchronous abort in the middle of CALC.
        step(4);
        reset = 1'b0;
        #1;
        check("abort_async_clear", crc_out, 6'h00);
        step(2);
        check("abort_held", crc_out, 6'h00);
        data_in = 32'h00000002;
        reset   = 1'b1;
        wait_done(e);
        check("restart_latency", 6'(e), 6'(PERIOD));
        check("restart_vec", crc_out, 6'h23);

        for (int k = 0; k < 200; k++) begin
            rd = $urandom;
            rp = 6'($urandom);
            data_in = rd;
            poly    = rp;
            wait_done(e);
            check("random_done", crc_out, crc_ref(rd, rp));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
